// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared external add/sub ALU.
// One operation in flight at a time: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_A,
  input  logic [2*WIDTH-1:0] req_B,
  input  logic [1:0]         req_Op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_S,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic               alu_Op,
  input  logic [WIDTH-1:0]   alu_S,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               accept_c;
  logic               gnt_sel_c;
  logic               gnt_q;
  logic               ptr_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic               op_q;
  logic [WIDTH-1:0]   res_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, grant selection and the combinational accept strobe
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    gnt_sel_c = ptr_q;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          accept_c = 1'b1;
          if (req_valid == 2'b01)      gnt_sel_c = 1'b0;
          else if (req_valid == 2'b10) gnt_sel_c = 1'b1;
          else                         gnt_sel_c = ptr_q;
          // Held low during reset so no grant is advertised while flops are cleared
          if (rst_n) req_ready[gnt_sel_c] = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, result capture and round-robin pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
      op_q  <= 1'b0;
      gnt_q <= 1'b0;
      ptr_q <= 1'b0;
      res_q <= '0;
    end else begin
      if (accept_c) begin
        opa_q <= gnt_sel_c ? req_A[2*WIDTH-1:WIDTH] : req_A[WIDTH-1:0];
        opb_q <= gnt_sel_c ? req_B[2*WIDTH-1:WIDTH] : req_B[WIDTH-1:0];
        op_q  <= req_Op[gnt_sel_c];
        gnt_q <= gnt_sel_c;
      end
      if (state_q == EXEC) res_q <= alu_S;
      if ((state_q == RESP) && rsp_ready[gnt_q]) ptr_q <= ~gnt_q;
    end
  end

  assign alu_A     = opa_q;
  assign alu_B     = opb_q;
  assign alu_Op    = op_q;
  assign rsp_S     = res_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural add/sub ALU attached.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 16;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_A;
  logic [2*WIDTH-1:0] req_B;
  logic [1:0]         req_Op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_S;
  logic [WIDTH-1:0]   alu_A;
  logic [WIDTH-1:0]   alu_B;
  logic               alu_Op;
  logic [WIDTH-1:0]   alu_S;
  logic               busy;

  typedef struct packed {
    logic             g;
    logic [WIDTH-1:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_Op(req_Op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_S(rsp_S),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_S(alu_S),
    .busy(busy)
  );

  assign alu_S = alu_Op ? WIDTH'(alu_A + alu_B) : WIDTH'(alu_A - alu_B);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic op);
    return op ? WIDTH'(a + b) : WIDTH'(a - b);
  endfunction

  // Pop and compare whenever a response is handed over
  always @(negedge clk) begin
    check("rr_onehot", 32'(req_ready == 2'b11), 32'd0);
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), e.g ? 32'd2 : 32'd1);
        check("rsp_S", 32'(rsp_S), 32'(e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu", {alu_Op, alu_B[14:0], alu_A}, 32'd0);
    check("rst_rsp_S", 32'(rsp_S), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Single-requester operation; operands scrambled right after acceptance
  task automatic do_op(input logic r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic op);
    logic [1:0] onehot;
    onehot = r ? 2'b10 : 2'b01;
    if (r) begin
      req_A[2*WIDTH-1:WIDTH] = a; req_B[2*WIDTH-1:WIDTH] = b; req_Op[1] = op;
    end else begin
      req_A[WIDTH-1:0] = a; req_B[WIDTH-1:0] = b; req_Op[0] = op;
    end
    req_valid = onehot;
    @(negedge clk);
    check("acc_ready", 32'(req_ready), 32'(onehot));
    sb.push_back(exp_t'{g: r, s: calc(a, b, op)});
    tick();
    req_valid = 2'b00;
    req_A     = 32'($urandom);
    req_B     = 32'($urandom);
    req_Op    = 2'($urandom);
    @(negedge clk);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_vld", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_vld", 32'(rsp_valid), 32'(onehot));
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_A     = '0;
    req_B     = '0;
    req_Op    = 2'b00;
    rsp_ready = 2'b11;
    do_reset();

    // Single requesters, including wrap-around in both directions
    do_op(1'b0, 16'h1234, 16'h0101, 1'b1);
    do_op(1'b1, 16'h0000, 16'h0001, 1'b0);
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b1);
    do_op(1'b0, 16'h4000, 16'h0001, 1'b0);

    // Continuous contention alternates grants starting at requester 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic [WIDTH-1:0] a0, b0, a1, b1;
      logic g;
      a0 = WIDTH'(16'h1000 + k); b0 = WIDTH'(16'h0011 * k);
      a1 = WIDTH'(16'h0100 * k); b1 = WIDTH'(16'h0203 + k);
      g  = k[0];
      req_A = {a1, a0}; req_B = {b1, b0}; req_Op = 2'b01;
      req_valid = 2'b11;
      @(negedge clk);
      check("rr_grant", 32'(req_ready), g ? 32'd2 : 32'd1);
      sb.push_back(exp_t'{g: g, s: g ? calc(a1, b1, 1'b0) : calc(a0, b0, 1'b1)});
      tick();
      @(negedge clk);
      check("rr_exec_ready", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
      check("rr_resp_ready", 32'(req_ready), 32'd0);
      if (k == 3) req_valid = 2'b00;
      tick();
    end

    // Response back-pressure; other requester waits and non-granted rsp_ready is ignored
    rsp_ready = 2'b10;
    req_A[WIDTH-1:0] = 16'h00F0; req_B[WIDTH-1:0] = 16'h0F00; req_Op[0] = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    check("stall_acc", 32'(req_ready), 32'd1);
    sb.push_back(exp_t'{g: 1'b0, s: 16'h0FF0});
    tick();
    req_valid = 2'b10;
    req_A[2*WIDTH-1:WIDTH] = 16'h0005; req_B[2*WIDTH-1:WIDTH] = 16'h0007; req_Op[1] = 1'b0;
    @(negedge clk);
    check("stall_exec_ready", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_vld", 32'(rsp_valid), 32'd1);
      check("stall_S", 32'(rsp_S), 32'h0FF0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    tick();
    rsp_ready = 2'b11;
    @(negedge clk);
    check("post_stall_acc", 32'(req_ready), 32'd2);
    sb.push_back(exp_t'{g: 1'b1, s: 16'hFFFE});
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    // Abort in EXEC: no response, pointer back to requester 0
    do_op(1'b0, 16'h0003, 16'h0004, 1'b1);
    req_A[2*WIDTH-1:WIDTH] = 16'hBEEF; req_B[2*WIDTH-1:WIDTH] = 16'h0001; req_Op[1] = 1'b1;
    req_valid = 2'b10;
    @(negedge clk);
    check("abort_acc", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vld", 32'(rsp_valid), 32'd0);
    check("abort_alu_A", 32'(alu_A), 32'd0);
    check("abort_rsp_S", 32'(rsp_S), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_quiet", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_A = {16'h2222, 16'h1111}; req_B = {16'h0002, 16'h0001}; req_Op = 2'b11;
    req_valid = 2'b11;
    @(negedge clk);
    check("abort_ptr0", 32'(req_ready), 32'd1);
    sb.push_back(exp_t'{g: 1'b0, s: 16'h1112});
    tick();
    req_valid = 2'b10;
    tick();
    tick();
    @(negedge clk);
    check("abort_next1", 32'(req_ready), 32'd2);
    sb.push_back(exp_t'{g: 1'b1, s: 16'h2224});
    tick();
    req_valid = 2'b00;
    repeat (4) tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
